sha512_pad: RTL and testbench
=============================

# sha512_pad

Message front end for the SHA-512 datapath. It accepts a message as a byte stream with a valid/ready handshake and applies FIPS 180-4 padding: a 0x80 byte, zero fill, and a 128-bit big-endian bit-length field. It emits whole 1024-bit chunks, with first/last markers, to the chunk compressor. Chunk byte order matches the compressor's word order, so message word 0 is `chunk[1023:960]`.

## Interface
- `LEN_W`, default 61: width of the internal message byte counter. The length field is `{(128-LEN_W-3)'b0, count, 3'b000}`. The counter wraps modulo 2^LEN_W.
- `clk` input 1: clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low.
- `in_valid` input 1: `in_data` and `in_last` are valid.
- `in_ready` output 1: the block accepts a byte this cycle; a byte transfers when `in_valid && in_ready`.
- `in_data` input 8: message byte.
- `in_last` input 1: this byte is the final byte of the message.
- `chunk_valid` output 1: `chunk` holds a complete chunk.
- `chunk_ready` input 1: the consumer takes the chunk; the chunk transfers when `chunk_valid && chunk_ready`.
- `chunk` output 1024: chunk data. Byte k (0..127) sits at `chunk[1023-8k -: 8]`.
- `chunk_first` output 1: this chunk is the first of a message; the consumer loads the IV.
- `chunk_last` output 1: this chunk is the final one; the digest is complete after compressing it.

## Operation
- Storage:
  - 128-byte buffer `buf`, driven straight onto `chunk`.
  - Byte index `idx` (7 bits).
  - Byte counter `cnt` (`LEN_W` bits).
  - Flags `first`, `final`, `tail_pad`, `tail_pend`.
- States:
  - FILL: `in_ready=1`.
    - On transfer: `buf[idx]<=in_data`, `idx<=idx+1`, `cnt<=cnt+1`.
    - Not last and `idx==127`: go to SEND with `final=0`.
    - Last: go to PAD.
  - PAD (one cycle): let `q` = byte count in `buf` (1..128, using `idx` after wrap: 0 means 128).
    - `q<=111`: `buf[q]<=8'h80`, length into bytes 112..127, `final=1`.
    - `112<=q<=127`: `buf[q]<=8'h80`, `final=0`, `tail_pend=1`, `tail_pad=0`.
    - `q==128`: `final=0`, `tail_pend=1`, `tail_pad=1`.
    - Go to SEND.
  - TAIL (one cycle): if `tail_pad`, `buf[0]<=8'h80`; length into bytes 112..127; `final=1`, `tail_pend=0`; go to SEND.
  - SEND: `chunk_valid=1`, `in_ready=0`.
    - On chunk transfer: `buf<=0`, `idx<=0`, `first<=0`.
    - If `final`: `cnt<=0`, `first<=1`, go to FILL.
    - Else if `tail_pend`: go to TAIL.
    - Else: go to FILL.
- `chunk_last` equals `final` while in SEND; `chunk_first` equals `first` while in SEND. Both are 0 outside SEND.
- Length is computed from the `cnt` value that includes the last byte.
- The buffer is zeroed on every chunk transfer, so zero fill needs no extra writes.
- Empty messages are not supported; every message has at least one byte.

## Timing
- Reset values:
  - State FILL, so `in_ready=1` from the first cycle after reset deassertion.
  - `chunk_valid=0`, `chunk_first=0`, `chunk_last=0`, `chunk=0`.
  - `idx=0`, `cnt=0`, `first=1`, all other flags 0.
- Latency:
  - A full (non-last) chunk: `chunk_valid` rises in the cycle after the 128th byte transfers.
  - A final byte: PAD takes 1 cycle, then SEND.
  - A tail chunk: TAIL takes 1 cycle after the previous chunk transfers, then SEND.
- Throughput: 1 byte/cycle in FILL. There is at least 1 non-accepting cycle per chunk (SEND), plus PAD and TAIL where applicable.
- `chunk` and the flags are held stable for the whole time `chunk_valid` is high, and change only after the transfer.
- `in_ready` is 0 in PAD, TAIL and SEND. `in_valid` may stay high and is ignored in those states.
- Reset asserted mid-message or mid-SEND: the partial message is discarded and all registers return to reset values immediately. No chunk is emitted.
- Counter overflow past 2^LEN_W bytes wraps silently; the length field carries the wrapped value.

## Test plan
- "abc" (61 62 63, last on 63): one chunk with first=1, last=1.
  - `chunk[1023:1000]=24'h616263`, `chunk[999:992]=8'h80`, `chunk[7:0]=8'h18`, all other bits 0.
  - Feeding it to the compressor with the IV yields the standard SHA-512("abc") digest.
- 111-byte message: one chunk, byte 111 = 0x80, bytes 112..127 = 128'h378, first=last=1.
- 112-byte message: two chunks.
  - Chunk 1: byte 112 = 0x80, bytes 113..127 = 0, last=0, first=1.
  - Chunk 2: all zero except bytes 112..127 = 128'h380, first=0, last=1.
- 128-byte message: two chunks.
  - Chunk 1: pure data, last=0.
  - Chunk 2: byte 0 = 0x80, length 128'h400, last=1.
- Backpressure: hold `chunk_ready=0` for 5 cycles during SEND. `chunk`, `chunk_first` and `chunk_last` stay constant and `in_ready=0` throughout. The transfer happens on the first cycle `chunk_ready=1`.
- Reset mid-message: after 50 bytes, pulse reset low. Outputs return to reset values and no chunk appears. A following "abc" message produces the exact chunk from the first scenario with first=1.

Source files
------------

// File: rtl/sha512_pad.sv
// sha512_pad: SHA-512 message front end.
// Accepts a byte stream and pads it: a 0x80 marker, zero fill, then a 128-bit
// big-endian bit length. The result leaves as 1024-bit chunks with first/last
// markers. Byte k of the buffer sits at chunk[1023-8k -: 8], so message word 0
// of the compressor lands in chunk[1023:960].
module sha512_pad #(
  parameter int LEN_W = 61
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  input  logic          in_last,
  output logic          chunk_valid,
  input  logic          chunk_ready,
  output logic [1023:0] chunk,
  output logic          chunk_first,
  output logic          chunk_last
);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_PAD  = 2'd1,
    S_TAIL = 2'd2,
    S_SEND = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [6:0]        idx_q, idx_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              first_q, first_d;
  logic              final_q, final_d;
  logic              tail_pad_q, tail_pad_d;
  logic              tail_pend_q, tail_pend_d;

  // The buffer is cleared in one cycle on every chunk hand-off, so it lives in
  // flops rather than RAM; zero fill then comes for free.
  logic [7:0]        buf_q [128];
  logic [7:0]        buf_d [128];

  logic              in_fire;
  logic              chunk_fire;
  logic              pad_mark;
  logic              len_wr;
  logic              tail_mark;
  logic [127:0]      len_field;

  // Bit length of the message; cnt_q already includes the final byte when
  // PAD or TAIL runs.
  assign len_field  = {{(128-LEN_W-3){1'b0}}, cnt_q, 3'b000};

  assign in_fire    = (state_q == S_FILL) && in_valid;
  assign chunk_fire = (state_q == S_SEND) && chunk_ready;
  // idx_q == 0 in PAD means the buffer is full (128 bytes): no room for 0x80.
  assign pad_mark   = (state_q == S_PAD) && (idx_q != 7'd0);
  // The length fits behind the marker only when at most 111 bytes are used.
  assign len_wr     = ((state_q == S_PAD) && (idx_q != 7'd0) && (idx_q <= 7'd111))
                    || (state_q == S_TAIL);
  assign tail_mark  = (state_q == S_TAIL) && tail_pad_q;

  // Per-byte next value: clear on hand-off, else data, marker or length.
  for (genvar gi = 0; gi < 128; gi++) begin : g_byte
    localparam bit IS_LEN  = (gi >= 112);
    localparam bit IS_HEAD = (gi == 0);

    assign buf_d[gi] = chunk_fire                            ? 8'h00 :
                       (in_fire  && (idx_q == 7'(gi)))       ? in_data :
                       (pad_mark && (idx_q == 7'(gi)))       ? 8'h80 :
                       (tail_mark && IS_HEAD)                ? 8'h80 :
                       (len_wr && IS_LEN)                    ? len_field[8*(127-gi) +: 8] :
                                                               buf_q[gi];

    assign chunk[8*(127-gi) +: 8] = buf_q[gi];
  end

  // Buffer register: cleared by reset, otherwise loads the per-byte next value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 128; i++) begin
        buf_q[i] <= 8'h00;
      end
    end else begin
      buf_q <= buf_d;
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_FILL;
      idx_q       <= 7'd0;
      cnt_q       <= '0;
      first_q     <= 1'b1;
      final_q     <= 1'b0;
      tail_pad_q  <= 1'b0;
      tail_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      final_q     <= final_d;
      tail_pad_q  <= tail_pad_d;
      tail_pend_q <= tail_pend_d;
    end
  end

  // Next-state and handshake outputs; everything defaults to hold / idle.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    first_d     = first_q;
    final_d     = final_q;
    tail_pad_d  = tail_pad_q;
    tail_pend_d = tail_pend_q;
    in_ready    = 1'b0;
    chunk_valid = 1'b0;
    chunk_first = 1'b0;
    chunk_last  = 1'b0;

    case (state_q)
      S_FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          idx_d = idx_q + 7'd1;
          cnt_d = cnt_q + LEN_W'(1);
          if (in_last) begin
            state_d = S_PAD;
          end else if (idx_q == 7'd127) begin
            final_d = 1'b0;
            state_d = S_SEND;
          end
        end
      end

      S_PAD: begin
        if (idx_q == 7'd0) begin
          // Buffer full: marker and length both go into a tail chunk.
          final_d     = 1'b0;
          tail_pend_d = 1'b1;
          tail_pad_d  = 1'b1;
        end else if (idx_q >= 7'd112) begin
          // Marker fits, length does not: tail chunk carries only the length.
          final_d     = 1'b0;
          tail_pend_d = 1'b1;
          tail_pad_d  = 1'b0;
        end else begin
          final_d     = 1'b1;
        end
        state_d = S_SEND;
      end

      S_TAIL: begin
        final_d     = 1'b1;
        tail_pend_d = 1'b0;
        state_d     = S_SEND;
      end

      S_SEND: begin
        chunk_valid = 1'b1;
        chunk_first = first_q;
        chunk_last  = final_q;
        if (chunk_ready) begin
          idx_d   = 7'd0;
          first_d = 1'b0;
          if (final_q) begin
            cnt_d   = '0;
            first_d = 1'b1;
            state_d = S_FILL;
          end else if (tail_pend_q) begin
            state_d = S_TAIL;
          end else begin
            state_d = S_FILL;
          end
        end
      end

      default: begin
        state_d = S_FILL;
      end
    endcase
  end

endmodule

// File: tb/tb_sha512_pad.sv
// tb_sha512_pad: directed and randomized checks of sha512_pad against a
// reference that pads whole messages as byte queues and slices them into chunks.
module tb_sha512_pad;

  typedef logic [7:0] bq_t [$];

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          in_last;
  logic          chunk_valid;
  logic          chunk_ready;
  logic [1023:0] chunk;
  logic          chunk_first;
  logic          chunk_last;

  int checks = 0;
  int errors = 0;

  logic [1023:0] exp_q [$];
  logic [1023:0] last_chunk;

  always #5 clk = ~clk;

  sha512_pad dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .chunk_valid (chunk_valid),
    .chunk_ready (chunk_ready),
    .chunk       (chunk),
    .chunk_first (chunk_first),
    .chunk_last  (chunk_last)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_chunk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    int k;
    checks++;
    assert (obs === exp) else begin
      errors++;
      k = 0;
      while (k < 127 && obs[1023-8*k -: 8] === exp[1023-8*k -: 8]) k++;
      $error("FAIL %s byte %0d observed=%02h expected=%02h", tag, k,
             obs[1023-8*k -: 8], exp[1023-8*k -: 8]);
    end
  endtask

  // Reference padding: message, 0x80, zeros up to 112 mod 128, 16-byte length.
  function automatic void model(input bq_t msg);
    bq_t p;
    logic [127:0] bits;
    logic [1023:0] v;
    p = msg;
    p.push_back(8'h80);
    while ((p.size() % 128) != 112) p.push_back(8'h00);
    bits = 128'(msg.size()) << 3;
    for (int j = 0; j < 16; j++) p.push_back(bits[8*(15-j) +: 8]);
    exp_q.delete();
    for (int c = 0; c < p.size() / 128; c++) begin
      v = '0;
      for (int k = 0; k < 128; k++) v[1023-8*k -: 8] = p[128*c + k];
      exp_q.push_back(v);
    end
  endfunction

  function automatic bq_t rand_msg(input int n);
    bq_t m;
    for (int i = 0; i < n; i++) m.push_back(8'($urandom_range(255)));
    return m;
  endfunction

  // Stream one message with random input gaps; bp=1 holds each chunk 5 cycles.
  task automatic run_msg(input string name, input bq_t msg, input bit bp);
    int pos, ci, vc, cyc, nch;
    model(msg);
    nch = exp_q.size();
    pos = 0; ci = 0; vc = 0; cyc = 0;
    while (ci < nch && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (pos < msg.size() && $urandom_range(3) != 0) begin
        in_valid = 1'b1;
        in_data  = msg[pos];
        in_last  = (pos == msg.size() - 1);
      end else begin
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
      end
      chunk_ready = bp ? (vc >= 5) : ($urandom_range(2) != 0);
      #1;
      if (chunk_valid) begin
        check_chunk({name, " chunk"}, chunk, exp_q[ci]);
        check({name, " first"}, 64'(chunk_first), 64'(ci == 0));
        check({name, " last"}, 64'(chunk_last), 64'(ci == nch - 1));
        check({name, " in_ready_send"}, 64'(in_ready), 64'd0);
        if (chunk_ready) begin
          $display("%s: chunk %0d/%0d first=%0b last=%0b", name, ci + 1, nch,
                   chunk_first, chunk_last);
          last_chunk = chunk;
          ci++;
          vc = 0;
        end else begin
          vc++;
        end
      end
      if (in_valid && in_ready) pos++;
    end
    check({name, " chunks_seen"}, 64'(ci), 64'(nch));
    check({name, " bytes_taken"}, 64'(pos), 64'(msg.size()));
    @(negedge clk);
    in_valid    = 1'b0;
    in_last     = 1'b0;
    chunk_ready = 1'b0;
  endtask

  initial begin
    bq_t abc;
    logic [1023:0] abc_exp;

    reset = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; chunk_ready = 1'b0;
    abc = '{8'h61, 8'h62, 8'h63};
    abc_exp = '0;
    abc_exp[1023:1000] = 24'h616263;
    abc_exp[999:992]   = 8'h80;
    abc_exp[7:0]       = 8'h18;

    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst in_ready", 64'(in_ready), 64'd1);
    check("rst chunk_valid", 64'(chunk_valid), 64'd0);
    check("rst chunk_first", 64'(chunk_first), 64'd0);
    check("rst chunk_last", 64'(chunk_last), 64'd0);
    check_chunk("rst chunk", chunk, '0);

    run_msg("abc", abc, 1'b0);
    check_chunk("abc exact", last_chunk, abc_exp);
    run_msg("len111", rand_msg(111), 1'b0);
    run_msg("len112", rand_msg(112), 1'b0);
    run_msg("len128_bp", rand_msg(128), 1'b1);
    run_msg("len127", rand_msg(127), 1'b0);
    run_msg("len256", rand_msg(256), 1'b0);
    run_msg("len1_bp", rand_msg(1), 1'b1);
    for (int r = 0; r < 6; r++) begin
      run_msg($sformatf("rand%0d", r), rand_msg($urandom_range(300, 1)), 1'b0);
    end

    // Mid-message reset: 50 bytes in, then reset; nothing may be emitted.
    chunk_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'($urandom_range(255));
      in_last  = 1'b0;
      #1;
      if (i == 49) check("mid chunk_valid", 64'(chunk_valid), 64'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("midrst chunk_valid", 64'(chunk_valid), 64'd0);
    check("midrst chunk_first", 64'(chunk_first), 64'd0);
    check("midrst chunk_last", 64'(chunk_last), 64'd0);
    check_chunk("midrst chunk", chunk, '0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chunk_ready = 1'b0;
    @(negedge clk);
    check("postrst in_ready", 64'(in_ready), 64'd1);
    check("postrst chunk_valid", 64'(chunk_valid), 64'd0);
    run_msg("abc_after_rst", abc, 1'b0);
    check_chunk("abc_after_rst exact", last_chunk, abc_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
